// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled step tick driving blink, bounce, binary count
// and PWM breathe patterns, with synchronised mode/enable controls.
module led_pattern_engine #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_HZ  = 2,
   parameter int N_LEDS   = 4,
   parameter int PWM_BITS = 8,
   parameter int TST_BIT  = 3
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [1:0]        MODE,
   input  logic              ENABLE,
   output logic [N_LEDS-1:0] LED,
   output logic              TICK,
   output logic              TSTA
);

   localparam int PERIOD = CLK_HZ / TICK_HZ;
   localparam int PS_W   = $clog2(PERIOD);
   localparam int POS_W  = $clog2(N_LEDS);

   localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PERIOD - 1);
   localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LEDS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   typedef enum logic [1:0] {
      MODE_BLINK   = 2'b00,
      MODE_BOUNCE  = 2'b01,
      MODE_COUNT   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   function automatic logic [N_LEDS-1:0] blink_init();
      logic [N_LEDS-1:0] r;
      for (int i = 0; i < N_LEDS; i++) r[i] = (i % 2 == 0);
      return r;
   endfunction

   localparam logic [N_LEDS-1:0] BLINK_INIT = blink_init();

   logic [PS_W-1:0]     ps_q, ps_d;
   logic                tick_q, tick_d;
   mode_e               mode_s1_q, mode_s2_q;
   logic                en_s1_q, en_s2_q;
   mode_e               mode_q, mode_d;
   logic [N_LEDS-1:0]   led_q, led_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                dir_up_q, dir_up_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                duty_up_q, duty_up_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;

   // NOTE: every variable gets a default at the top of the block so no path
   // through the case/if tree can leave it unassigned and infer a latch.
   always_comb begin
      ps_d      = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
      tick_d    = (ps_q == PS_LAST);
      pwm_d     = pwm_q + PWM_BITS'(1);
      mode_d    = mode_q;
      led_d     = led_q;
      pos_d     = pos_q;
      dir_up_d  = dir_up_q;
      duty_d    = duty_q;
      duty_up_d = duty_up_q;

      // Breathe refreshes the LEDs every cycle from the PWM comparison.
      if (mode_q == MODE_BREATHE) led_d = {N_LEDS{pwm_q < duty_q}};

      if (tick_q) begin
         if (mode_s2_q != mode_q) begin
            mode_d    = mode_s2_q;
            pos_d     = '0;
            dir_up_d  = 1'b1;
            duty_d    = '0;
            duty_up_d = 1'b1;
            case (mode_s2_q)
               MODE_BLINK:  led_d = BLINK_INIT;
               MODE_BOUNCE: led_d = N_LEDS'(1);
               default:     led_d = '0;
            endcase
         end else if (en_s2_q) begin
            case (mode_q)
               MODE_BLINK: led_d = ~led_q;
               MODE_BOUNCE: begin
                  if (pos_q == (dir_up_q ? POS_LAST : '0)) dir_up_d = !dir_up_q;
                  pos_d = dir_up_d ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                  led_d = N_LEDS'(1) << pos_d;
               end
               MODE_COUNT: led_d = led_q + N_LEDS'(1);
               default: begin
                  if (duty_q == (duty_up_q ? DUTY_MAX : '0)) duty_up_d = !duty_up_q;
                  duty_d = duty_up_d ? duty_q + PWM_BITS'(1) : duty_q - PWM_BITS'(1);
               end
            endcase
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ps_q      <= '0;
         tick_q    <= 1'b0;
         mode_s1_q <= MODE_BLINK;
         mode_s2_q <= MODE_BLINK;
         en_s1_q   <= 1'b0;
         en_s2_q   <= 1'b0;
         mode_q    <= MODE_BLINK;
         led_q     <= BLINK_INIT;
         pos_q     <= '0;
         dir_up_q  <= 1'b1;
         duty_q    <= '0;
         duty_up_q <= 1'b1;
         pwm_q     <= '0;
      end else begin
         ps_q      <= ps_d;
         tick_q    <= tick_d;
         mode_s1_q <= mode_e'(MODE);
         mode_s2_q <= mode_s1_q;
         en_s1_q   <= ENABLE;
         en_s2_q   <= en_s1_q;
         mode_q    <= mode_d;
         led_q     <= led_d;
         pos_q     <= pos_d;
         dir_up_q  <= dir_up_d;
         duty_q    <= duty_d;
         duty_up_q <= duty_up_d;
         pwm_q     <= pwm_d;
      end
   end

   assign LED  = led_q;
   assign TICK = tick_q;
   assign TSTA = ps_q[TST_BIT];

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Parameters
REQ-001 CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 TICK_HZ, default 2, pattern step rate in Hz; PERIOD = CLK_HZ/TICK_HZ, legal range PERIOD >= 4.
REQ-003 N_LEDS, default 4, LED channel count, legal range 2..16.
REQ-004 PWM_BITS, default 8, breathe-mode duty/PWM width, legal range 2..12.
REQ-005 TST_BIT, default 3, prescaler bit driven onto TSTA, legal range 0..$clog2(PERIOD)-1.

Interface
REQ-006 CLK  input  1  system clock; all state changes on its rising edge.
REQ-007 RST_N  input  1  reset; asynchronous, active-low.
REQ-008 MODE  input  2  pattern select; asynchronous to CLK.
REQ-009 ENABLE  input  1  pattern advance enable, active-high; asynchronous to CLK.
REQ-010 LED  output  N_LEDS  pattern output, bit 0 = LED1.
REQ-011 TICK  output  1  one-cycle strobe at TICK_HZ.
REQ-012 TSTA  output  1  test signal, CLK/2^(TST_BIT+1).

Function
REQ-013 MODE and ENABLE shall each pass through a 2-flop synchroniser before use.
REQ-014 Prescaler: width $clog2(PERIOD); counts 0..PERIOD-1, then wraps to 0.
REQ-015 TICK shall be registered and high for exactly the one cycle after the prescaler wraps; period exactly PERIOD cycles; first assertion PERIOD cycles after RST_N deasserts.
REQ-016 TSTA shall equal prescaler bit TST_BIT, independent of MODE and ENABLE.
REQ-017 Pattern state shall update only on edges where TICK is high; LED changes one cycle after TICK rises.
REQ-018 On a TICK edge where synchronised MODE differs from active mode: load the new mode and its init state; ignore ENABLE for that edge.
REQ-019 Otherwise, on a TICK edge with synchronised ENABLE low: hold the pattern state; prescaler, TICK and TSTA keep running.
REQ-020 Mode 00 BLINK: init LED = even bits set (…0101); each step inverts all LED bits.
REQ-021 Mode 01 BOUNCE: one-hot position pos, direction dir; init pos=0, dir=up; step pos±1; at pos=N_LEDS-1 going up, reverse and go to N_LEDS-2; at pos=0 going down, reverse and go to 1; end LEDs lit for one step per pass.
REQ-022 Mode 10 COUNT: LED = binary count; init 0; increments by 1, wraps 2^N_LEDS-1 -> 0.
REQ-023 Mode 11 BREATHE: free-running PWM counter, PWM_BITS wide, increments every CLK; all LED bits = (pwm_cnt < duty).
REQ-024 BREATHE duty: init duty=0, ramp up; step ±1 per step; at 2^PWM_BITS-1 going up, reverse to 2^PWM_BITS-2; at 0 going down, reverse to 1; duty 0 = LEDs fully off.
REQ-025 LED outputs shall be registered, with no combinational path from MODE or ENABLE.

Reset
REQ-026 While RST_N is low: prescaler=0, TICK=0, TSTA=0, synchronisers=0, active mode=00, LED = BLINK init (…0101), bounce pos=0/dir=up, duty=0, PWM counter=0.
REQ-027 An RST_N assertion mid-operation shall return all state to REQ-026 values immediately, without waiting for CLK.
REQ-028 After RST_N deasserts, operation resumes from the REQ-026 state, starting at the first rising edge of CLK.

Verification (CLK_HZ=16, TICK_HZ=2 -> PERIOD=8, N_LEDS=4, PWM_BITS=3, TST_BIT=1)
REQ-029 Reset release, MODE=00, ENABLE=1 -> TICK pulses at cycles 8,16,24…; LED 0101 -> 1010 -> 0101; TSTA toggles every 2 cycles.
REQ-030 MODE=01 held -> after mode-load tick, LED sequence 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-031 MODE=10, ENABLE=1 for 18 ticks -> LED counts 0..15, then 0, 1; ENABLE=0 for 3 ticks -> LED frozen while TICK still pulses.
REQ-032 MODE=11 -> duty 0,1..7,6..0,1; at duty=3, LED all-high exactly 3 of every 8 cycles; at duty=0, LEDs never high.
REQ-033 MODE changed 01->10 mid-period with ENABLE=0 -> no LED change until next TICK, then LED=0000.
REQ-034 RST_N pulsed low between clock edges during BOUNCE at pos=2 -> LED=0101 and TICK=0 immediately; next TICK 8 cycles after release.
